spike_rate_decoder: RTL and testbench
=====================================

# spike_rate_decoder

Converts a 1-bit spike train into numeric form: counts spikes over a programmable window and measures the most recent inter-spike interval (ISI) inside that window. It sits downstream of the LIF neuron's `spike` output and recovers an estimate of the driving input current. Results are presented on a valid/ready output port.

## Interface

Parameters:
- `WINDOW_BITS`, 6: width of `window_len`; maximum window is 2^WINDOW_BITS cycles.
- `COUNT_WIDTH`, 8: width of `rate_out`; the spike count saturates at 2^COUNT_WIDTH-1.
- `ISI_WIDTH`, 8: width of `isi_out`; the ISI saturates at 2^ISI_WIDTH-1.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `spike_in` in 1: spike train, sampled every COUNT cycle.
- `enable` in 1: run windows while high.
- `window_len` in WINDOW_BITS: window length minus 1, sampled at each window start.
- `rate_out` out COUNT_WIDTH: spike count of the last completed window.
- `isi_out` out ISI_WIDTH: last ISI within that window.
- `out_valid` out 1: a result is held on `rate_out`/`isi_out`.
- `out_ready` in 1: the consumer accepts the result.
- `overrun` out 1: sticky flag; a completed result was dropped.
- `busy` out 1: high while in COUNT.

## Operation

- The state machine has two states, IDLE and COUNT.
- **IDLE:**
  - Window counter and spike/ISI accumulators are cleared.
  - On a clock edge with `enable`=1: go to COUNT, load `wcnt` := `window_len`, clear accumulators.
- **COUNT:**
  - `spike_in` is sampled every cycle, including the last cycle of the window.
  - Spike count: incremented on each sampled spike, saturating.
  - ISI tracking: timer counts cycles since the previous spike in this window. For spikes sampled at cycles t1 < t2, the ISI is t2-t1, saturating. Only the most recent ISI is kept. The ISI is 0 if fewer than two spikes occurred in the window.
  - `wcnt` decrements each cycle. The window is L+1 cycles, where L = latched `window_len`.
- **Window end** (COUNT cycle with `wcnt`=0):
  - The result is offered to the output register.
  - If `enable`=1, the next window starts on the following cycle: `window_len` is resampled, accumulators are cleared, and no gap cycle is inserted.
  - If `enable`=0, the next state is IDLE.
- **`enable` deasserted mid-window:** go to IDLE, discard partial counts, emit no result.
- **Output register:**
  - Loaded when a result is offered and either (`out_valid`=0) or (`out_valid`=1 and `out_ready`=1 in the same cycle). In the latter case, the old result is consumed and the new one is loaded with no overrun.
  - When `out_valid`=1 and `out_ready`=0 at a window end: the new result is discarded, the held result is unchanged, and `overrun` is set.
  - `out_valid` clears on `out_valid`&&`out_ready` when no new result is offered that cycle.
  - `rate_out` and `isi_out` are stable while `out_valid`=1 and not accepted.
- **`overrun`:** cleared only by `reset`.
- **`reset` (any time, including mid-window or with `out_valid`=1):** go to IDLE. All outputs are 0 on the cycle after the reset edge: `rate_out`=0, `isi_out`=0, `out_valid`=0, `overrun`=0, `busy`=0.

## Timing

- Take cycle 0 as the first cycle with `enable`=1 in IDLE. COUNT occupies cycles 1..L+1, and `spike_in` is sampled in those cycles.
- `out_valid` rises in cycle L+2, with the result registered at the end edge of cycle L+1. Latency from the last sampled spike to `out_valid` is 1 cycle.
- Back-to-back windows: result n+1 is offered exactly L+1 cycles after result n.
- `busy` is a registered copy of the state: 1 in cycles 1..L+1 and 0 in IDLE.
- All outputs are registered. There is no combinational path from inputs to outputs.
- The window counter never wraps: `window_len`=2^WINDOW_BITS-1 gives a 2^WINDOW_BITS-cycle window. `window_len`=0 gives a 1-cycle window, which yields count 0 or 1 with ISI 0.

## Test plan

- `window_len`=7, `spike_in`=1 continuously, `out_ready`=1 -> `out_valid` pulses every 8 cycles with `rate_out`=8, `isi_out`=1; first `out_valid` in cycle 9.
- `window_len`=15, spikes only at window cycles 3 and 10 -> `rate_out`=2, `isi_out`=7; single spike in a window -> `rate_out`=1, `isi_out`=0.
- `out_ready`=0 over two consecutive windows with distinct spike counts (3 then 5) -> first result (3) held, `overrun`=1. Then `out_ready`=1 -> `out_valid` drops after one cycle with `rate_out` still 3. Also cover `out_ready`=1 on the window-end cycle -> new result loaded, `overrun` stays 0.
- `COUNT_WIDTH`=4, `ISI_WIDTH`=4, `window_len`=31, continuous spikes -> `rate_out`=15 (saturated). Separately, spikes 20 cycles apart in one window -> `isi_out`=15.
- `enable` dropped at window cycle 4 of 8 -> no `out_valid`, `busy`=0 next cycle. Re-enable -> fresh window, count excludes earlier spikes.
- `reset` asserted mid-window while `out_valid`=1 and `overrun`=1 -> next cycle all outputs 0 and state IDLE; with `enable` held high, a new window starts the cycle after `reset` releases.

Source files
------------

// File: rtl/spike_rate_decoder.sv
// Spike-train decoder: counts spikes and tracks the latest inter-spike interval over a
// programmable window, presenting each completed window's result on a valid/ready port.
module spike_rate_decoder #(
  parameter int unsigned WINDOW_BITS = 6,
  parameter int unsigned COUNT_WIDTH = 8,
  parameter int unsigned ISI_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   spike_in,
  input  logic                   enable,
  input  logic [WINDOW_BITS-1:0] window_len,
  output logic [COUNT_WIDTH-1:0] rate_out,
  output logic [ISI_WIDTH-1:0]   isi_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   overrun,
  output logic                   busy
);

  typedef enum logic [0:0] {StIdle, StCount} state_e;

  localparam logic [COUNT_WIDTH-1:0] CntMax = '1;
  localparam logic [COUNT_WIDTH-1:0] CntOne = COUNT_WIDTH'(1);
  localparam logic [ISI_WIDTH-1:0]   IsiMax = '1;
  localparam logic [ISI_WIDTH-1:0]   IsiOne = ISI_WIDTH'(1);
  localparam logic [WINDOW_BITS-1:0] WinOne = WINDOW_BITS'(1);

  state_e                 state_q, state_d;
  logic [WINDOW_BITS-1:0] wcnt_q, wcnt_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [ISI_WIDTH-1:0]   isi_q, isi_d;
  logic [ISI_WIDTH-1:0]   timer_q, timer_d;
  logic                   seen_q, seen_d;
  logic [COUNT_WIDTH-1:0] rate_q, rate_d;
  logic [ISI_WIDTH-1:0]   isi_out_q, isi_out_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;

  logic                   offer;
  logic                   load;
  logic [COUNT_WIDTH-1:0] res_cnt;
  logic [ISI_WIDTH-1:0]   res_isi;
  logic [ISI_WIDTH-1:0]   timer_nxt;

  // Window accumulators; res_* already include this cycle's sample so the last cycle counts.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    cnt_d     = '0;
    isi_d     = '0;
    timer_d   = '0;
    seen_d    = 1'b0;
    offer     = 1'b0;
    res_cnt   = cnt_q;
    res_isi   = isi_q;
    timer_nxt = timer_q;

    if (spike_in) begin
      if (cnt_q != CntMax) res_cnt = cnt_q + CntOne;
      if (seen_q) res_isi = timer_q;
      timer_nxt = IsiOne;
    end else if (timer_q != IsiMax) begin
      timer_nxt = timer_q + IsiOne;
    end

    unique case (state_q)
      StIdle: begin
        wcnt_d = '0;
        if (enable) begin
          state_d = StCount;
          wcnt_d  = window_len;
        end
      end
      StCount: begin
        if (wcnt_q == '0) begin
          offer = 1'b1;
          if (enable) begin
            wcnt_d = window_len;
          end else begin
            state_d = StIdle;
            wcnt_d  = '0;
          end
        end else if (!enable) begin
          state_d = StIdle;
          wcnt_d  = '0;
        end else begin
          wcnt_d  = wcnt_q - WinOne;
          cnt_d   = res_cnt;
          isi_d   = res_isi;
          timer_d = timer_nxt;
          seen_d  = seen_q | spike_in;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A held result is replaced only when it is consumed in the same cycle.
  always_comb begin
    load      = offer && (!valid_q || out_ready);
    rate_d    = rate_q;
    isi_out_d = isi_out_q;
    valid_d   = valid_q;
    overrun_d = overrun_q | (offer && valid_q && !out_ready);
    if (load) begin
      rate_d    = res_cnt;
      isi_out_d = res_isi;
      valid_d   = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      wcnt_q    <= '0;
      cnt_q     <= '0;
      isi_q     <= '0;
      timer_q   <= '0;
      seen_q    <= 1'b0;
      rate_q    <= '0;
      isi_out_q <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      cnt_q     <= cnt_d;
      isi_q     <= isi_d;
      timer_q   <= timer_d;
      seen_q    <= seen_d;
      rate_q    <= rate_d;
      isi_out_q <= isi_out_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign rate_out  = rate_q;
  assign isi_out   = isi_out_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q == StCount);

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: a default-width instance and a 4-bit instance share
// stimulus so saturation can be observed alongside the normal results.
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       spike_in;
  logic       enable;
  logic [5:0] window_len;
  logic       out_ready;

  logic [7:0] rate_out;
  logic [7:0] isi_out;
  logic       out_valid;
  logic       overrun;
  logic       busy;

  logic [3:0] rate4;
  logic [3:0] isi4;
  logic       valid4;
  logic       overrun4;
  logic       busy4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spike_rate_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .spike_in  (spike_in),
    .enable    (enable),
    .window_len(window_len),
    .rate_out  (rate_out),
    .isi_out   (isi_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .busy      (busy)
  );

  spike_rate_decoder #(
    .WINDOW_BITS(6),
    .COUNT_WIDTH(4),
    .ISI_WIDTH  (4)
  ) dut4 (
    .clk       (clk),
    .reset     (reset),
    .spike_in  (spike_in),
    .enable    (enable),
    .window_len(window_len),
    .rate_out  (rate4),
    .isi_out   (isi4),
    .out_valid (valid4),
    .out_ready (out_ready),
    .overrun   (overrun4),
    .busy      (busy4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one window; mask bit i is the spike for window cycle i+1. Returns in the cycle
  // where the result becomes visible (first cycle of the next window when keep_en is set).
  task automatic run_window(input int len, input logic [63:0] mask, input bit do_start,
                            input bit keep_en, input logic rdy_end);
    if (do_start) begin
      window_len = 6'(len);
      enable     = 1'b1;
      spike_in   = 1'b0;
      tick();
    end
    for (int i = 0; i <= len; i++) begin
      spike_in = mask[i];
      if (i == len) begin
        out_ready = rdy_end;
        if (!keep_en) enable = 1'b0;
      end
      tick();
    end
    spike_in = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    spike_in   = 1'b0;
    enable     = 1'b0;
    window_len = 6'd7;
    out_ready  = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_rate", 32'(rate_out), 0);
    chk("rst_isi", 32'(isi_out), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_busy", 32'(busy), 0);

    // Continuous spikes, L=7: first result in cycle 9, then every 8 cycles.
    spike_in = 1'b1;
    enable   = 1'b1;
    tick();
    chk("c1_busy", 32'(busy), 1);
    chk("c1_valid", 32'(out_valid), 0);
    repeat (7) tick();
    chk("c8_valid", 32'(out_valid), 0);
    tick();
    chk("c9_valid", 32'(out_valid), 1);
    chk("c9_rate", 32'(rate_out), 8);
    chk("c9_isi", 32'(isi_out), 1);
    chk("c9_rate4", 32'(rate4), 8);
    tick();
    chk("c10_valid", 32'(out_valid), 0);
    repeat (6) tick();
    chk("c16_valid", 32'(out_valid), 0);
    tick();
    chk("c17_valid", 32'(out_valid), 1);
    chk("c17_rate", 32'(rate_out), 8);
    enable   = 1'b0;
    spike_in = 1'b0;
    tick();
    chk("c18_busy", 32'(busy), 0);
    chk("c18_valid", 32'(out_valid), 0);

    // Two spikes at window cycles 3 and 10.
    run_window(15, 64'h204, 1'b1, 1'b0, 1'b1);
    chk("isi7_valid", 32'(out_valid), 1);
    chk("isi7_rate", 32'(rate_out), 2);
    chk("isi7_isi", 32'(isi_out), 7);
    tick();
    chk("isi7_drop", 32'(out_valid), 0);
    run_window(15, 64'h20, 1'b1, 1'b0, 1'b1);
    chk("single_rate", 32'(rate_out), 1);
    chk("single_isi", 32'(isi_out), 0);
    tick();
    run_window(0, 64'h1, 1'b1, 1'b0, 1'b1);
    chk("w0_valid", 32'(out_valid), 1);
    chk("w0_rate", 32'(rate_out), 1);
    chk("w0_isi", 32'(isi_out), 0);
    tick();

    // Held result accepted on the same cycle a new one arrives: no overrun.
    out_ready = 1'b0;
    run_window(7, 64'h3, 1'b1, 1'b1, 1'b0);
    chk("hold_rate", 32'(rate_out), 2);
    run_window(7, 64'hF, 1'b0, 1'b0, 1'b1);
    chk("swap_valid", 32'(out_valid), 1);
    chk("swap_rate", 32'(rate_out), 4);
    chk("swap_overrun", 32'(overrun), 0);
    tick();
    chk("swap_drop", 32'(out_valid), 0);

    // Consumer stalled across two windows: first result kept, overrun raised.
    out_ready = 1'b0;
    run_window(7, 64'h7, 1'b1, 1'b1, 1'b0);
    chk("ovr_a_rate", 32'(rate_out), 3);
    chk("ovr_a_overrun", 32'(overrun), 0);
    run_window(7, 64'h1F, 1'b0, 1'b0, 1'b0);
    chk("ovr_b_valid", 32'(out_valid), 1);
    chk("ovr_b_rate", 32'(rate_out), 3);
    chk("ovr_b_overrun", 32'(overrun), 1);
    out_ready = 1'b1;
    tick();
    chk("ovr_drop", 32'(out_valid), 0);
    chk("ovr_rate_held", 32'(rate_out), 3);

    // Saturation on the narrow instance.
    run_window(31, 64'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
    chk("sat_rate8", 32'(rate_out), 32);
    chk("sat_rate4", 32'(rate4), 15);
    chk("sat_isi4", 32'(isi4), 1);
    tick();
    run_window(31, 64'h10_0001, 1'b1, 1'b0, 1'b1);
    chk("gap_isi8", 32'(isi_out), 20);
    chk("gap_isi4", 32'(isi4), 15);
    chk("gap_rate4", 32'(rate4), 2);
    tick();

    // Abort at window cycle 4, then a fresh window.
    window_len = 6'd7;
    enable     = 1'b1;
    spike_in   = 1'b1;
    repeat (4) tick();
    enable = 1'b0;
    tick();
    spike_in = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(out_valid), 0);
    repeat (9) tick();
    chk("abort_still", 32'(out_valid), 0);
    run_window(7, 64'h2, 1'b1, 1'b0, 1'b1);
    chk("fresh_rate", 32'(rate_out), 1);
    chk("fresh_isi", 32'(isi_out), 0);
    tick();

    // Reset mid-window with a held result and overrun set.
    out_ready = 1'b0;
    run_window(7, 64'h1, 1'b1, 1'b1, 1'b0);
    run_window(7, 64'h1, 1'b0, 1'b1, 1'b0);
    chk("pre_rst_valid", 32'(out_valid), 1);
    chk("pre_rst_overrun", 32'(overrun), 1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_rate", 32'(rate_out), 0);
    chk("mid_rst_isi", 32'(isi_out), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_overrun", 32'(overrun), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    reset = 1'b0;
    tick();
    chk("post_rst_busy", 32'(busy), 1);
    enable = 1'b0;
    tick();
    chk("post_rst_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
